// File: rtl/cfg_loader_pkg.sv
// Shared state encoding, response codes and sizing helper for the config frame loader.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StPayload,
    StCheck,
    StResp
  } state_e;

  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;
  localparam logic [7:0] RESP_CAN = 8'h18;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_word_packer.sv
// Shifts payload bytes MSB first into a WORD_WIDTH word; the finished word is held
// in its own register and announced with a one-cycle done pulse.
module cfg_word_packer
  import cfg_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  clear_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  last_byte_o,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  word_done_o
);

  localparam int unsigned Bytes = WORD_WIDTH / 8;
  localparam int unsigned CntW  = cnt_width(Bytes);

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d, word_q, word_d, shifted;
  logic                  done_q, done_d;

  assign shifted     = (shift_q << 8) | WORD_WIDTH'(byte_i);
  assign last_byte_o = (cnt_q == CntW'(Bytes - 1));
  assign word_o      = word_q;
  assign word_done_o = done_q;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    done_d  = 1'b0;
    if (clear_i) begin
      // Drops a partial word; the last completed word stays visible.
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid_i) begin
      shift_d = shifted;
      if (last_byte_o) begin
        cnt_d  = '0;
        word_d = shifted;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/cfg_frame_loader.sv
// Framed byte-to-word config loader between the CDC byte streams and the eFPGA config port.
// Define CFG_FRAME_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module cfg_frame_loader
  import cfg_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1_200_000
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [7:0]            out_data_i,
  input  logic                  out_valid_i,
  output logic                  out_ready_o,
  output logic [7:0]            in_data_o,
  output logic                  in_valid_o,
  input  logic                  in_ready_i,
  output logic [WORD_WIDTH-1:0] write_data_o,
  output logic                  word_write_strobe_o,
  output logic                  busy_o
);

  localparam int unsigned TmoW = cnt_width(TIMEOUT_CYCLES);

  state_e          state_q, state_d;
  logic [15:0]     len_q, len_d, wcnt_q, wcnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [7:0]      resp_q, resp_d;
  logic            accept, counting, timed_out, pk_valid, pk_clear, pk_last;
`ifdef CFG_FRAME_LOADER_CHECKSUM_EN
  logic [7:0]      chk_q, chk_d;
`endif

  assign out_ready_o = (state_q != StResp);
  assign accept      = out_valid_i & out_ready_o;
  assign in_valid_o  = (state_q == StResp);
  assign in_data_o   = in_valid_o ? resp_q : 8'h00;
  assign busy_o      = (state_q != StIdle);
  assign counting    = state_q inside {StLenHi, StLenLo, StPayload, StCheck};
  // Fires after TIMEOUT_CYCLES consecutive cycles without a byte; a byte in that cycle wins.
  assign timed_out   = counting && !accept && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
  assign pk_valid    = (state_q == StPayload) && accept;
  assign pk_clear    = timed_out || (state_q == StIdle);

  cfg_word_packer #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_packer (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .clear_i     (pk_clear),
    .byte_valid_i(pk_valid),
    .byte_i      (out_data_i),
    .last_byte_o (pk_last),
    .word_o      (write_data_o),
    .word_done_o (word_write_strobe_o)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    resp_d  = resp_q;
    tmo_d   = (counting && !accept) ? tmo_q + 1'b1 : '0;
`ifdef CFG_FRAME_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
    if (counting && accept) chk_d = chk_q ^ out_data_i;
`endif
    if (timed_out) begin
      state_d = StResp;
      resp_d  = RESP_CAN;
      wcnt_d  = '0;
      tmo_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept && out_data_i == SYNC_BYTE) begin
            state_d = StLenHi;
            wcnt_d  = '0;
`ifdef CFG_FRAME_LOADER_CHECKSUM_EN
            chk_d   = '0;
`endif
          end
        end
        StLenHi: begin
          if (accept) begin
            len_d   = {out_data_i, len_q[7:0]};
            state_d = StLenLo;
          end
        end
        StLenLo: begin
          if (accept) begin
            len_d = {len_q[15:8], out_data_i};
            if ({len_q[15:8], out_data_i} == 16'd0) begin
`ifdef CFG_FRAME_LOADER_CHECKSUM_EN
              state_d = StCheck;
`else
              state_d = StResp;
              resp_d  = RESP_ACK;
`endif
            end else begin
              state_d = StPayload;
            end
          end
        end
        StPayload: begin
          if (accept && pk_last) begin
            wcnt_d = wcnt_q + 16'd1;
            if (wcnt_q == len_q - 16'd1) begin
`ifdef CFG_FRAME_LOADER_CHECKSUM_EN
              state_d = StCheck;
`else
              state_d = StResp;
              resp_d  = RESP_ACK;
`endif
            end
          end
        end
`ifdef CFG_FRAME_LOADER_CHECKSUM_EN
        StCheck: begin
          if (accept) begin
            state_d = StResp;
            resp_d  = (out_data_i == chk_q) ? RESP_ACK : RESP_NAK;
          end
        end
`endif
        StResp: begin
          if (in_ready_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      len_q   <= '0;
      wcnt_q  <= '0;
      tmo_q   <= '0;
      resp_q  <= '0;
`ifdef CFG_FRAME_LOADER_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
      resp_q  <= resp_d;
`ifdef CFG_FRAME_LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

endmodule
